// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and default widths for the SRAM port arbiter
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;

  // Bus ownership: RD serves the VGA reader, WR drives a buffered engine write,
  // HOLD keeps address/data on the pins for one cycle after we_n rises.
  typedef enum logic [1:0] {
    RD   = 2'd0,
    WR   = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - engine write port, VGA read port and SRAM pin bundle
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
);

  localparam int PEND_W = $clog2(FIFO_DEPTH) + 1;

  // Engine write port
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [PEND_W-1:0] wr_pending;

  // VGA read port
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_grant;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  // SRAM pins (tristate resolved in the top level)
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_out;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_in;
  logic              ce_n;
  logic              oe_n;
  logic              we_n;
  logic              ub_n;
  logic              lb_n;

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready, wr_pending,
    input  rd_req, rd_addr,
    output rd_grant, rd_data, rd_valid,
    output sram_addr, sram_dq_out, sram_dq_oe,
    input  sram_dq_in,
    output ce_n, oe_n, we_n, ub_n, lb_n
  );

  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready, wr_pending,
    output rd_req, rd_addr,
    input  rd_grant, rd_data, rd_valid,
    input  sram_addr, sram_dq_out, sram_dq_oe,
    output sram_dq_in,
    input  ce_n, oe_n, we_n, ub_n, lb_n
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Full is judged before any same-cycle pop, so a freed slot is usable next cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count keeps the extra bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM between buffered engine writes and the VGA reader
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int WE_CYCLES  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sram_port_arbiter_if.slave   bus
);

  localparam int PEND_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W  = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam int ENT_W  = ADDR_W + DATA_W;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_we_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic              w_wr_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_rd_grant;
  logic [ENT_W-1:0]  w_head;
  logic [PEND_W-1:0] w_count;

  assign w_wr_ready = !w_full && !i_rst;
  assign w_push     = bus.wr_valid && w_wr_ready;

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  ({bus.wr_addr, bus.wr_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, FIFO pop and read grant; the reader always wins when asking in RD/HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_rd_grant  = 1'b0;
    unique case (r_state)
      RD: begin
        w_rd_grant = bus.rd_req;
        if (!bus.rd_req && !w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = WR;
        end
      end
      WR: begin
        if (r_we_cnt == '0) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (!bus.rd_req && !w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = WR;
        end else begin
          w_state_nxt = RD;
        end
      end
      default: w_state_nxt = RD;
    endcase
    if (i_rst) begin
      w_pop      = 1'b0;
      w_rd_grant = 1'b0;
    end
  end

  // Address/data output registers, we_n pulse counter and registered read data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_dout     <= '0;
      r_we_cnt   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_grant;
      if (w_rd_grant) begin
        r_rd_data <= bus.sram_dq_in;
        r_addr    <= bus.rd_addr;
      end
      if (w_pop) begin
        r_addr   <= w_head[ENT_W-1:DATA_W];
        r_dout   <= w_head[DATA_W-1:0];
        r_we_cnt <= CNT_W'(WE_CYCLES - 1);
      end else if (r_state == WR && r_we_cnt != '0) begin
        r_we_cnt <= r_we_cnt - 1'b1;
      end
    end
  end

  // A granted read puts rd_addr straight on the pins so data returns next edge.
  assign bus.sram_addr   = w_rd_grant ? bus.rd_addr : r_addr;
  assign bus.sram_dq_out = r_dout;
  assign bus.sram_dq_oe  = (r_state != RD);
  assign bus.oe_n        = (r_state != RD);
  assign bus.we_n        = (r_state != WR);
  assign bus.ce_n        = 1'b0;
  assign bus.ub_n        = 1'b0;
  assign bus.lb_n        = 1'b0;
  assign bus.wr_ready    = w_wr_ready;
  assign bus.wr_pending  = w_count;
  assign bus.rd_grant    = w_rd_grant;
  assign bus.rd_data     = r_rd_data;
  assign bus.rd_valid    = r_rd_valid;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

  logic clk;
  logic rst;
  logic load_mem;
  int   passed;
  int   total;
  int   we_low_cycles;
  int   we_snap;
  logic [15:0] mem [0:255];

  sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(16), .FIFO_DEPTH(4)) bus ();

  sram_port_arbiter #(
    .ADDR_W     (20),
    .DATA_W     (16),
    .FIFO_DEPTH (4),
    .WE_CYCLES  (2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  function automatic logic [15:0] init_word(input logic [7:0] a);
    if (a == 8'h10) return 16'hBEEF;
    return {a, ~a};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM model: combinational read, write on clock edges with we_n low.
  assign bus.sram_dq_in = mem[bus.sram_addr[7:0]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
      we_low_cycles <= 0;
    end else begin
      if (!bus.we_n && bus.sram_dq_oe) mem[bus.sram_addr[7:0]] <= bus.sram_dq_out;
      if (!bus.we_n) we_low_cycles <= we_low_cycles + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_mem = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    step(); step();
    load_mem = 1'b0;
    step();
    total++; if (bus.wr_ready !== 1'b0) $display("FAIL rst_wr_ready: got %b want 0", bus.wr_ready); else passed++;
    total++; if (bus.wr_pending !== 3'd0) $display("FAIL rst_wr_pending: got %0d want 0", bus.wr_pending); else passed++;
    total++; if (bus.rd_grant !== 1'b0) $display("FAIL rst_rd_grant: got %b want 0", bus.rd_grant); else passed++;
    total++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0) $display("FAIL rst_rd_out: got %b/%h want 0/0000", bus.rd_valid, bus.rd_data); else passed++;
    total++; if (bus.sram_addr !== 20'h0 || bus.sram_dq_out !== 16'h0) $display("FAIL rst_addr_data: got %h/%h want 0/0", bus.sram_addr, bus.sram_dq_out); else passed++;
    total++; if ({bus.sram_dq_oe, bus.oe_n, bus.we_n} !== 3'b001) $display("FAIL rst_ctrl: got oe/oe_n/we_n %b want 001", {bus.sram_dq_oe, bus.oe_n, bus.we_n}); else passed++;
    total++; if ({bus.ce_n, bus.ub_n, bus.lb_n} !== 3'b000) $display("FAIL rst_ce_ub_lb: got %b want 000", {bus.ce_n, bus.ub_n, bus.lb_n}); else passed++;
    rst = 1'b0;
    step();
    total++; if (bus.wr_ready !== 1'b1) $display("FAIL idle_wr_ready: got %b want 1", bus.wr_ready); else passed++;
    total++; if ({bus.sram_dq_oe, bus.oe_n, bus.we_n} !== 3'b001) $display("FAIL idle_ctrl: got %b want 001", {bus.sram_dq_oe, bus.oe_n, bus.we_n}); else passed++;
    total++; if (bus.wr_pending !== 3'd0) $display("FAIL idle_pending: got %0d want 0", bus.wr_pending); else passed++;
  endtask

  task automatic test_read_stream();
    bus.rd_req = 1'b1; bus.rd_addr = 20'h00010;
    #1;
    total++; if (bus.rd_grant !== 1'b1 || bus.sram_addr !== 20'h00010) $display("FAIL rd_grant_addr: got %b/%h want 1/00010", bus.rd_grant, bus.sram_addr); else passed++;
    step();
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'hBEEF) $display("FAIL rd_first: got %b/%h want 1/beef", bus.rd_valid, bus.rd_data); else passed++;
    for (int k = 0; k < 16; k++) begin
      bus.rd_addr = 20'h00010 + 20'(k);
      step();
      total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== init_word(8'(16 + k))) $display("FAIL rd_stream_%0d: got %b/%h want 1/%h", k, bus.rd_valid, bus.rd_data, init_word(8'(16 + k))); else passed++;
    end
    bus.rd_req = 1'b0;
    step();
    total++; if (bus.rd_valid !== 1'b0 || bus.sram_addr !== 20'h0001F) $display("FAIL rd_stop: got %b/%h want 0/0001f", bus.rd_valid, bus.sram_addr); else passed++;
  endtask

  task automatic test_single_write();
    we_snap = we_low_cycles;
    bus.wr_valid = 1'b1; bus.wr_addr = 20'h00005; bus.wr_data = 16'h1234;
    #1;
    total++; if (bus.wr_ready !== 1'b1) $display("FAIL wr1_ready: got %b want 1", bus.wr_ready); else passed++;
    step();
    bus.wr_valid = 1'b0;
    total++; if (bus.wr_pending !== 3'd1 || bus.we_n !== 1'b1) $display("FAIL wr1_queued: got %0d/%b want 1/1", bus.wr_pending, bus.we_n); else passed++;
    step();
    total++; if (bus.we_n !== 1'b0 || bus.sram_addr !== 20'h00005 || bus.sram_dq_out !== 16'h1234) $display("FAIL wr1_cyc1: got %b/%h/%h want 0/00005/1234", bus.we_n, bus.sram_addr, bus.sram_dq_out); else passed++;
    total++; if ({bus.sram_dq_oe, bus.oe_n} !== 2'b11 || bus.wr_pending !== 3'd0) $display("FAIL wr1_drive: got %b/%0d want 11/0", {bus.sram_dq_oe, bus.oe_n}, bus.wr_pending); else passed++;
    step();
    total++; if (bus.we_n !== 1'b0) $display("FAIL wr1_cyc2: got %b want 0", bus.we_n); else passed++;
    step();
    total++; if (bus.we_n !== 1'b1 || bus.sram_dq_oe !== 1'b1 || bus.sram_addr !== 20'h00005) $display("FAIL wr1_hold: got %b/%b/%h want 1/1/00005", bus.we_n, bus.sram_dq_oe, bus.sram_addr); else passed++;
    step();
    total++; if (bus.sram_dq_oe !== 1'b0 || bus.oe_n !== 1'b0) $display("FAIL wr1_back_rd: got %b/%b want 0/0", bus.sram_dq_oe, bus.oe_n); else passed++;
    total++; if (mem[5] !== 16'h1234 || (we_low_cycles - we_snap) != 2) $display("FAIL wr1_mem: got %h/%0d want 1234/2", mem[5], we_low_cycles - we_snap); else passed++;
  endtask

  task automatic test_back_to_back();
    bus.rd_req = 1'b1; bus.rd_addr = 20'h00010;
    we_snap = we_low_cycles;
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 20'h00020 + 20'(i); bus.wr_data = 16'hA000 + 16'(i);
      #1;
      total++; if (bus.wr_ready !== (i < 4)) $display("FAIL b2b_ready_%0d: got %b want %b", i, bus.wr_ready, (i < 4)); else passed++;
      step();
    end
    bus.wr_valid = 1'b0;
    total++; if (bus.wr_pending !== 3'd4 || we_low_cycles != we_snap) $display("FAIL b2b_full: got %0d/%0d want 4/0", bus.wr_pending, we_low_cycles - we_snap); else passed++;
    bus.rd_req = 1'b0;
    step();
    for (int j = 0; j < 4; j++) begin
      total++; if (bus.wr_pending !== 3'(3 - j) || bus.we_n !== 1'b0 || bus.sram_addr !== 20'h00020 + 20'(j) || bus.sram_dq_out !== 16'hA000 + 16'(j)) $display("FAIL b2b_wr_%0d: got %0d/%b/%h/%h want %0d/0/%h/%h", j, bus.wr_pending, bus.we_n, bus.sram_addr, bus.sram_dq_out, 3 - j, 20'h00020 + 20'(j), 16'hA000 + 16'(j)); else passed++;
      step();
      total++; if (bus.we_n !== 1'b0) $display("FAIL b2b_cyc2_%0d: got %b want 0", j, bus.we_n); else passed++;
      step();
      total++; if (bus.we_n !== 1'b1 || bus.sram_dq_oe !== 1'b1) $display("FAIL b2b_hold_%0d: got %b/%b want 1/1", j, bus.we_n, bus.sram_dq_oe); else passed++;
      step();
    end
    total++; if (bus.sram_dq_oe !== 1'b0 || bus.wr_pending !== 3'd0) $display("FAIL b2b_done: got %b/%0d want 0/0", bus.sram_dq_oe, bus.wr_pending); else passed++;
    for (int j = 0; j < 4; j++) begin
      total++; if (mem[8'h20 + j] !== 16'hA000 + 16'(j)) $display("FAIL b2b_mem_%0d: got %h want %h", j, mem[8'h20 + j], 16'hA000 + 16'(j)); else passed++;
    end
  endtask

  task automatic test_read_during_write();
    bus.wr_valid = 1'b1; bus.wr_addr = 20'h00030; bus.wr_data = 16'h5A5A;
    step();
    bus.wr_valid = 1'b0;
    step();
    bus.rd_req = 1'b1; bus.rd_addr = 20'h00030;
    #1;
    total++; if (bus.rd_grant !== 1'b0 || bus.we_n !== 1'b0) $display("FAIL rdw_wr1: got %b/%b want 0/0", bus.rd_grant, bus.we_n); else passed++;
    step();
    total++; if (bus.rd_grant !== 1'b0 || bus.we_n !== 1'b0) $display("FAIL rdw_wr2: got %b/%b want 0/0", bus.rd_grant, bus.we_n); else passed++;
    step();
    total++; if (bus.rd_grant !== 1'b0 || bus.we_n !== 1'b1) $display("FAIL rdw_hold: got %b/%b want 0/1", bus.rd_grant, bus.we_n); else passed++;
    step();
    total++; if (bus.rd_grant !== 1'b1 || bus.sram_addr !== 20'h00030) $display("FAIL rdw_grant: got %b/%h want 1/00030", bus.rd_grant, bus.sram_addr); else passed++;
    step();
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h5A5A) $display("FAIL rdw_data: got %b/%h want 1/5a5a", bus.rd_valid, bus.rd_data); else passed++;
    bus.rd_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_write();
    bus.rd_req = 1'b1; bus.rd_addr = 20'h00010;
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 20'h00040 + 20'(i); bus.wr_data = 16'hC000 + 16'(i);
      step();
    end
    bus.wr_valid = 1'b0;
    total++; if (bus.wr_pending !== 3'd3) $display("FAIL rmw_queued: got %0d want 3", bus.wr_pending); else passed++;
    we_snap = we_low_cycles;
    bus.rd_req = 1'b0;
    step();
    total++; if (bus.we_n !== 1'b0 || bus.wr_pending !== 3'd2) $display("FAIL rmw_wr1: got %b/%0d want 0/2", bus.we_n, bus.wr_pending); else passed++;
    rst = 1'b1;
    step();
    total++; if (bus.we_n !== 1'b1 || bus.wr_pending !== 3'd0 || bus.wr_ready !== 1'b0) $display("FAIL rmw_reset: got %b/%0d/%b want 1/0/0", bus.we_n, bus.wr_pending, bus.wr_ready); else passed++;
    rst = 1'b0;
    repeat (8) step();
    total++; if ((we_low_cycles - we_snap) != 1 || bus.we_n !== 1'b1 || bus.wr_pending !== 3'd0) $display("FAIL rmw_no_more: got %0d/%b/%0d want 1/1/0", we_low_cycles - we_snap, bus.we_n, bus.wr_pending); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_read_stream();
    test_single_write();
    test_back_to_back();
    test_read_during_write();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
